// File: rtl/if_id_queue_pkg.sv
// Shared types and defaults for the fetch-to-decode instruction queue.
// Both the queue top and its entry storage import this package.
package if_id_queue_pkg;

  localparam int          IF_ID_DEPTH = 4;
  localparam int          IF_ID_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_file.sv
// DEPTH x fetch_entry_t storage: one synchronous write port and one asynchronous read port.
// The array is data-only and has no reset; the queue pointers decide which entries are live.
module fetch_entry_file
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IF_ID_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_entry_t rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: buffers {pc, instr} pairs, drives fetch Freeze
// through full, and empties itself on a taken branch (flush) or reset.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IF_ID_DEPTH,
  parameter int WIDTH = IF_ID_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  logic [WIDTH-1:0]           enq_pc,
  input  logic [WIDTH-1:0]           enq_instr,
  output logic                       full,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [WIDTH-1:0]           deq_pc,
  output logic [WIDTH-1:0]           deq_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic         enq_fire;
  logic         deq_fire;
  logic         wr_en;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;

  // Flags come from registered state only, never from this cycle's handshakes.
  assign full      = (count_q == CW'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign count     = count_q;

  assign enq_fire = enq_valid && !full;
  assign deq_fire = deq_valid && deq_ready;

  // A flushed enqueue must not leave a trace, so the write is suppressed too.
  assign wr_en          = enq_fire && !flush && !rst;
  assign wr_entry.pc    = 32'(enq_pc);
  assign wr_entry.instr = 32'(enq_instr);

  fetch_entry_file #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_entries (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // An empty queue presents pc 0 and a NOP so decode does nothing harmful.
  assign deq_pc    = deq_valid ? WIDTH'(rd_entry.pc)    : '0;
  assign deq_instr = deq_valid ? WIDTH'(rd_entry.instr) : WIDTH'(NOP_INSTR);

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a queue-based reference model checked every cycle.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             enq_valid;
  logic [WIDTH-1:0] enq_pc;
  logic [WIDTH-1:0] enq_instr;
  logic             full;
  logic             deq_ready;
  logic             deq_valid;
  logic [WIDTH-1:0] deq_pc;
  logic [WIDTH-1:0] deq_instr;
  logic [2:0]       count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .full      (full),
    .deq_ready (deq_ready),
    .deq_valid (deq_valid),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC0DE_0000 | pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {pc, instr}, updated from the sampled handshakes.
  logic [63:0] mq[$];
  bit          m_enq, m_deq;

  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
    end else begin
      m_deq = (mq.size() != 0) && deq_ready;
      m_enq = enq_valid && (mq.size() < DEPTH);
      if (m_deq) void'(mq.pop_front());
      if (m_enq) mq.push_back({enq_pc, enq_instr});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_full",  32'(full), 32'(mq.size() == DEPTH));
      chk("m_valid", 32'(deq_valid), 32'(mq.size() != 0));
      chk("m_pc",    deq_pc,    (mq.size() != 0) ? mq[0][63:32] : 32'h0);
      chk("m_instr", deq_instr, (mq.size() != 0) ? mq[0][31:0]  : 32'h0);
    end
  end

  task automatic tick(input bit ev, input logic [31:0] pc, input bit dr,
                      input bit fl, input bit rs);
    @(negedge clk);
    #1;
    enq_valid = ev;
    enq_pc    = pc;
    enq_instr = instr_of(pc);
    deq_ready = dr;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_pc = '0; enq_instr = '0; deq_ready = 1'b0;

    // Reset held two cycles with enqueue requested.
    tick(1, 32'd100, 0, 0, 1);
    chk_en = 1'b1;
    tick(1, 32'd100, 0, 0, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(deq_valid), 32'd0);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_pc",    deq_pc, 32'd0);
    chk("rst_instr", deq_instr, 32'd0);
    tick(0, 32'd0, 0, 0, 0);

    // Fill to full, then a dropped fifth enqueue.
    for (int i = 1; i <= 4; i++) tick(1, 32'(i), 0, 0, 0);
    chk("fill_full",  32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    tick(1, 32'd5, 0, 0, 0);
    chk("drop5_count", 32'(count), 32'd4);
    chk("drop5_head",  deq_pc, 32'd1);
    chk("drop5_instr", deq_instr, 32'hC0DE_0001);

    // Drain in order.
    for (int i = 1; i <= 3; i++) begin
      tick(0, 32'd0, 1, 0, 0);
      chk("drain_pc", deq_pc, 32'(i + 1));
    end
    tick(0, 32'd0, 1, 0, 0);
    chk("drain_empty", 32'(deq_valid), 32'd0);
    chk("drain_pc0",   deq_pc, 32'd0);

    // Streaming from empty: one in, one out each cycle, wraps the pointers twice.
    for (int i = 0; i < 10; i++) begin
      tick(1, 32'(20 + i), 1, 0, 0);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_pc",    deq_pc, 32'(20 + i));
    end
    tick(0, 32'd0, 1, 0, 0);
    chk("stream_end", 32'(count), 32'd0);

    // Flush wins over a same-cycle enqueue and dequeue.
    for (int i = 31; i <= 33; i++) tick(1, 32'(i), 0, 0, 0);
    tick(1, 32'd9, 1, 1, 0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(deq_valid), 32'd0);
    tick(1, 32'd10, 0, 0, 0);
    chk("postflush_count", 32'(count), 32'd1);
    chk("postflush_pc",    deq_pc, 32'd10);
    tick(0, 32'd0, 1, 0, 0);

    // Full with a simultaneous dequeue: the enqueue is ignored.
    for (int i = 41; i <= 44; i++) tick(1, 32'(i), 0, 0, 0);
    tick(1, 32'd7, 1, 0, 0);
    chk("fulldeq_count", 32'(count), 32'd3);
    chk("fulldeq_full",  32'(full), 32'd0);
    chk("fulldeq_head",  deq_pc, 32'd42);
    tick(1, 32'd7, 0, 0, 0);
    chk("re7_count", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) tick(0, 32'd0, 1, 0, 0);
    chk("re7_head", deq_pc, 32'd7);
    tick(0, 32'd0, 1, 0, 0);
    chk("re7_empty", 32'(deq_valid), 32'd0);

    // Reset mid-operation drops the in-flight handshake.
    tick(1, 32'd51, 0, 0, 0);
    tick(1, 32'd52, 0, 0, 0);
    tick(1, 32'd53, 1, 0, 1);
    chk("midrst_count", 32'(count), 32'd0);
    tick(1, 32'd60, 0, 0, 0);
    chk("midrst_enq_count", 32'(count), 32'd1);
    chk("midrst_enq_pc",    deq_pc, 32'd60);
    tick(0, 32'd0, 1, 0, 0);
    tick(0, 32'd0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
